// File: rtl/sd_ctrl_pkg.sv
// rtl/sd_ctrl_pkg.sv - shared types and defaults for the scan doubler controller
// Contents: FSM state enum, scanline mode encoding, default parameter values.
package sd_ctrl_pkg;

   localparam int DEF_HCNT_W        = 10;
   localparam int DEF_VCNT_W        = 10;
   localparam int DEF_MIN_HTOTAL    = 256;
   localparam int DEF_STABLE_FRAMES = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } sd_state_t;

   typedef logic [1:0] scan_mode_t;

   localparam scan_mode_t SL_NONE = 2'd0;
   localparam scan_mode_t SL_25   = 2'd1;
   localparam scan_mode_t SL_50   = 2'd2;
   localparam scan_mode_t SL_75   = 2'd3;

endpackage

// File: rtl/sd_ctrl_if.sv
// rtl/sd_ctrl_if.sv - sync input / committed timing output bundle of sd_ctrl
// master: drives ce_pix, hs_in, vs_in, force_bypass, scan_req; reads results.
// slave : the controller; drives hs_max, hs_rise, lines, locked, sd_enable,
//         scanlines, mode_change.
interface sd_ctrl_if #(
   parameter int HCNT_W = 10,
   parameter int VCNT_W = 10
);
   logic              ce_pix;
   logic              hs_in;
   logic              vs_in;
   logic              force_bypass;
   logic              scan_req;
   logic [HCNT_W-1:0] hs_max;
   logic [HCNT_W-1:0] hs_rise;
   logic [VCNT_W-1:0] lines;
   logic              locked;
   logic              sd_enable;
   logic [1:0]        scanlines;
   logic              mode_change;

   modport master (
      output ce_pix, hs_in, vs_in, force_bypass, scan_req,
      input  hs_max, hs_rise, lines, locked, sd_enable, scanlines, mode_change
   );

   modport slave (
      input  ce_pix, hs_in, vs_in, force_bypass, scan_req,
      output hs_max, hs_rise, lines, locked, sd_enable, scanlines, mode_change
   );
endinterface

// File: rtl/sd_sync_meter.sv
// rtl/sd_sync_meter.sv - measures line total, hsync rise and lines per frame
// Inputs : clk_x2, reset_n, ce_pix, hs_in, vs_in.
// Outputs: frame_strobe (1 clk after vs rise), timeout (hcnt just saturated),
//          cur_htot, cur_rise, cur_lines, cur_valid (stable at frame_strobe).
module sd_sync_meter
   import sd_ctrl_pkg::*;
#(
   parameter int HCNT_W     = DEF_HCNT_W,
   parameter int VCNT_W     = DEF_VCNT_W,
   parameter int MIN_HTOTAL = DEF_MIN_HTOTAL
) (
   input  logic              clk_x2,
   input  logic              reset_n,
   input  logic              ce_pix,
   input  logic              hs_in,
   input  logic              vs_in,
   output logic              frame_strobe,
   output logic              timeout,
   output logic [HCNT_W-1:0] cur_htot,
   output logic [HCNT_W-1:0] cur_rise,
   output logic [VCNT_W-1:0] cur_lines,
   output logic              cur_valid
);
   localparam logic [HCNT_W-1:0] H_MAX = '1;
   localparam logic [VCNT_W-1:0] V_MAX = '1;
   localparam logic [HCNT_W-1:0] H_MIN = HCNT_W'(MIN_HTOTAL - 1);

   logic              hs_q;
   logic              vs_q;
   logic              hsat_seen;
   logic              vsat_seen;
   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              line_start;
   logic              hs_rise_e;
   logic              frame_start;
   logic [HCNT_W-1:0] hcnt_inc;
   logic [HCNT_W-1:0] htot_now;
   logic [VCNT_W-1:0] vcnt_line;

   assign line_start  = ce_pix & hs_q & ~hs_in;
   assign hs_rise_e   = ce_pix & ~hs_q & hs_in;
   assign frame_start = ce_pix & ~vs_q & vs_in;

   assign hcnt_inc = (hcnt == H_MAX) ? H_MAX : hcnt + 1'b1;

   // Line start is folded in before the frame capture so a line ending on the
   // vs edge is counted in the frame it closes.
   assign vcnt_line = (line_start && (vcnt != V_MAX)) ? vcnt + 1'b1 : vcnt;
   assign htot_now  = line_start ? hcnt : cur_htot;

   always_ff @(posedge clk_x2 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q         <= 1'b0;
         vs_q         <= 1'b0;
         hsat_seen    <= 1'b0;
         vsat_seen    <= 1'b0;
         hcnt         <= '0;
         vcnt         <= '0;
         frame_strobe <= 1'b0;
         timeout      <= 1'b0;
         cur_htot     <= '0;
         cur_rise     <= '0;
         cur_lines    <= '0;
         cur_valid    <= 1'b0;
      end else begin
         frame_strobe <= frame_start;
         // Fires once, on the ce cycle that pushes hcnt into saturation.
         timeout      <= ce_pix & ~line_start & (hcnt == H_MAX - 1'b1);
         if (ce_pix) begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            if (line_start) begin
               hcnt     <= '0;
               cur_htot <= hcnt;
            end else begin
               hcnt <= hcnt_inc;
            end
            if (hs_rise_e) begin
               cur_rise <= hcnt;
            end
            if (frame_start) begin
               cur_lines <= vcnt_line;
               vcnt      <= '0;
               cur_valid <= (htot_now >= H_MIN) && !hsat_seen && (hcnt != H_MAX)
                            && !vsat_seen && (vcnt_line != V_MAX);
               hsat_seen <= 1'b0;
               vsat_seen <= 1'b0;
            end else begin
               vcnt      <= vcnt_line;
               hsat_seen <= hsat_seen | (hcnt == H_MAX);
               vsat_seen <= vsat_seen | (vcnt_line == V_MAX);
            end
         end
      end
   end

endmodule

// File: rtl/sd_ctrl.sv
// rtl/sd_ctrl.sv - scan doubler lock FSM and frame-boundary mode commit
// Ports: clk_x2, reset_n (async, active low), bus (sd_ctrl_if.slave):
//   in : ce_pix, hs_in, vs_in, force_bypass, scan_req
//   out: hs_max, hs_rise, lines, locked, sd_enable, scanlines, mode_change
module sd_ctrl
   import sd_ctrl_pkg::*;
#(
   parameter int HCNT_W        = DEF_HCNT_W,
   parameter int VCNT_W        = DEF_VCNT_W,
   parameter int MIN_HTOTAL    = DEF_MIN_HTOTAL,
   parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
   input  logic     clk_x2,
   input  logic     reset_n,
   sd_ctrl_if.slave bus
);
   localparam logic [3:0] LOCK_AT = 4'(STABLE_FRAMES - 1);

   logic              frame_strobe;
   logic              timeout;
   logic [HCNT_W-1:0] cur_htot;
   logic [HCNT_W-1:0] cur_rise;
   logic [VCNT_W-1:0] cur_lines;
   logic              cur_valid;

   sd_state_t         state;
   logic [3:0]        stable_cnt;
   logic [HCNT_W-1:0] prev_htot;
   logic [VCNT_W-1:0] prev_lines;
   logic              scan_q;
   scan_mode_t        scan_pend;
   logic [HCNT_W-1:0] hs_max_q;
   logic [HCNT_W-1:0] hs_rise_q;
   logic [VCNT_W-1:0] lines_q;
   logic              sd_enable_q;
   scan_mode_t        scanlines_q;
   logic              mode_change_q;

   logic [HCNT_W-1:0] htot_diff;
   logic              frame_match;
   logic              scan_rise;
   scan_mode_t        scan_next;
   logic              go_lock;
   logic              commit_en;

   sd_sync_meter #(
      .HCNT_W     (HCNT_W),
      .VCNT_W     (VCNT_W),
      .MIN_HTOTAL (MIN_HTOTAL)
   ) u_meter (
      .clk_x2       (clk_x2),
      .reset_n      (reset_n),
      .ce_pix       (bus.ce_pix),
      .hs_in        (bus.hs_in),
      .vs_in        (bus.vs_in),
      .frame_strobe (frame_strobe),
      .timeout      (timeout),
      .cur_htot     (cur_htot),
      .cur_rise     (cur_rise),
      .cur_lines    (cur_lines),
      .cur_valid    (cur_valid)
   );

   assign htot_diff   = (cur_htot >= prev_htot) ? cur_htot - prev_htot : prev_htot - cur_htot;
   assign frame_match = cur_valid && (cur_lines == prev_lines) && (htot_diff <= HCNT_W'(1));

   // A request edge landing on the commit cycle is counted into that commit.
   assign scan_rise = bus.ce_pix & bus.scan_req & ~scan_q;
   assign scan_next = scan_pend + {1'b0, scan_rise};

   // True when the FSM will sit in LOCKED after this frame boundary.
   assign go_lock   = frame_strobe && frame_match &&
                      ((state == LOCKED) || ((state == MEASURE) && (stable_cnt == LOCK_AT)));
   assign commit_en = go_lock & ~bus.force_bypass;

   always_ff @(posedge clk_x2 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         stable_cnt    <= '0;
         prev_htot     <= '0;
         prev_lines    <= '0;
         scan_q        <= 1'b0;
         scan_pend     <= SL_NONE;
         hs_max_q      <= '0;
         hs_rise_q     <= '0;
         lines_q       <= '0;
         sd_enable_q   <= 1'b0;
         scanlines_q   <= SL_NONE;
         mode_change_q <= 1'b0;
      end else begin
         mode_change_q <= 1'b0;
         scan_pend     <= scan_next;
         if (bus.ce_pix) begin
            scan_q <= bus.scan_req;
         end
         if (timeout) begin
            // Lost hsync: drop to bypass now rather than waiting for a vs edge
            // that may never come.
            state         <= IDLE;
            stable_cnt    <= '0;
            sd_enable_q   <= 1'b0;
            mode_change_q <= sd_enable_q;
         end else if (frame_strobe) begin
            prev_htot  <= cur_htot;
            prev_lines <= cur_lines;
            case (state)
               IDLE: begin
                  state      <= MEASURE;
                  stable_cnt <= '0;
               end
               MEASURE: begin
                  if (!frame_match) begin
                     stable_cnt <= '0;
                  end else if (stable_cnt == LOCK_AT) begin
                     state     <= LOCKED;
                     hs_max_q  <= cur_htot;
                     hs_rise_q <= cur_rise;
                     lines_q   <= cur_lines;
                  end else begin
                     stable_cnt <= stable_cnt + 4'd1;
                  end
               end
               LOCKED: begin
                  if (frame_match) begin
                     hs_max_q  <= cur_htot;
                     hs_rise_q <= cur_rise;
                  end else begin
                     state      <= MEASURE;
                     stable_cnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
            sd_enable_q   <= commit_en;
            scanlines_q   <= scan_next;
            mode_change_q <= (commit_en != sd_enable_q) || (scan_next != scanlines_q);
         end
      end
   end

   assign bus.hs_max      = hs_max_q;
   assign bus.hs_rise     = hs_rise_q;
   assign bus.lines       = lines_q;
   assign bus.locked      = (state == LOCKED);
   assign bus.sd_enable   = sd_enable_q;
   assign bus.scanlines   = scanlines_q;
   assign bus.mode_change = mode_change_q;

endmodule

// File: tb/tb_sd_ctrl.sv
// tb/tb_sd_ctrl.sv - self-checking bench for sd_ctrl
module tb_sd_ctrl;

   typedef struct {
      int htot;
      int rise_p;
      int locked;
      int en;
      int hs_max;
      int hs_rise;
      int lines;
      int mc;
   } vec_t;

   logic clk_x2 = 1'b0;
   logic reset_n = 1'b0;

   sd_ctrl_if #(.HCNT_W(10), .VCNT_W(10)) bus ();

   sd_ctrl #(
      .HCNT_W        (10),
      .VCNT_W        (10),
      .MIN_HTOTAL    (256),
      .STABLE_FRAMES (4)
   ) dut (
      .clk_x2  (clk_x2),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk_x2 = ~clk_x2;

   int   n_chk = 0;
   int   n_fail = 0;
   int   mc_cnt = 0;
   int   mc_wide = 0;
   logic mc_prev = 1'b0;

   int   htot = 448;
   int   rise_p = 401;
   int   nlines = 4;
   int   pos = 0;
   int   line = 0;
   int   step_n = 0;
   logic scan_lvl = 1'b0;

   vec_t tbl [12];

   always @(negedge clk_x2) begin
      if (bus.mode_change) mc_cnt <= mc_cnt + 1;
      if (bus.mode_change && mc_prev) mc_wide <= mc_wide + 1;
      mc_prev <= bus.mode_change;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One ce cycle; every third call is preceded by a ce-low cycle carrying
   // inverted inputs, which the design must ignore.
   task automatic ce_step(input logic hs, input logic vs);
      step_n++;
      if (step_n % 3 == 0) begin
         bus.ce_pix   = 1'b0;
         bus.hs_in    = ~hs;
         bus.vs_in    = ~vs;
         bus.scan_req = ~scan_lvl;
         @(posedge clk_x2); #1;
      end
      bus.ce_pix   = 1'b1;
      bus.hs_in    = hs;
      bus.vs_in    = vs;
      bus.scan_req = scan_lvl;
      @(posedge clk_x2); #1;
   endtask

   // Line starts where hs falls (position 0); hs is high from rise_p to the
   // end of the line, so the captured rise offset is rise_p-1 and the
   // captured line total is htot-1. vs is high on lines 0 and 1.
   task automatic adv();
      pos++;
      if (pos == htot) begin
         pos = 0;
         line++;
         if (line == nlines) line = 0;
      end
      ce_step(pos >= rise_p, line < 2);
   endtask

   task automatic run_frame();
      adv();
      while (!(line == 0 && pos == 0)) adv();
   endtask

   task automatic settle();
      bus.ce_pix = 1'b0;
      bus.hs_in  = ~bus.hs_in;
      bus.vs_in  = ~bus.vs_in;
      repeat (2) begin
         @(posedge clk_x2); #1;
      end
   endtask

   task automatic pulse_scan();
      scan_lvl = 1'b1;
      adv();
      scan_lvl = 1'b0;
      adv();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hs_max"}, bus.hs_max, 0);
      chk({tag, "_hs_rise"}, bus.hs_rise, 0);
      chk({tag, "_lines"}, bus.lines, 0);
      chk({tag, "_locked"}, bus.locked, 0);
      chk({tag, "_sd_enable"}, bus.sd_enable, 0);
      chk({tag, "_scanlines"}, bus.scanlines, 0);
      chk({tag, "_mode_change"}, bus.mode_change, 0);
   endtask

   initial begin
      //          htot rise lk en hs_max rise lines mc
      tbl[0]  = '{448, 401, 0, 0,   0,   0,  0, 0};
      tbl[1]  = '{448, 401, 0, 0,   0,   0,  0, 0};
      tbl[2]  = '{448, 401, 0, 0,   0,   0,  0, 0};
      tbl[3]  = '{448, 401, 0, 0,   0,   0,  0, 0};
      tbl[4]  = '{448, 401, 1, 1, 447, 400,  4, 1};
      tbl[5]  = '{449, 411, 1, 1, 448, 410,  4, 1};
      tbl[6]  = '{460, 401, 0, 0, 448, 410,  4, 2};
      tbl[7]  = '{448, 401, 0, 0, 448, 410,  4, 2};
      tbl[8]  = '{448, 401, 0, 0, 448, 410,  4, 2};
      tbl[9]  = '{448, 401, 0, 0, 448, 410,  4, 2};
      tbl[10] = '{448, 401, 0, 0, 448, 410,  4, 2};
      tbl[11] = '{448, 401, 1, 1, 447, 400,  4, 3};

      bus.ce_pix       = 1'b0;
      bus.hs_in        = 1'b0;
      bus.vs_in        = 1'b0;
      bus.force_bypass = 1'b0;
      bus.scan_req     = 1'b0;
      repeat (3) begin
         @(posedge clk_x2); #1;
      end
      reset_n = 1'b1;
      @(posedge clk_x2); #1;
      chk_all_zero("reset");

      // First frame start: IDLE -> MEASURE.
      ce_step(1'b0, 1'b1);

      for (int i = 0; i < 12; i++) begin
         htot   = tbl[i].htot;
         rise_p = tbl[i].rise_p;
         run_frame();
         settle();
         chk($sformatf("v%0d_locked", i), bus.locked, tbl[i].locked);
         chk($sformatf("v%0d_sd_enable", i), bus.sd_enable, tbl[i].en);
         chk($sformatf("v%0d_hs_max", i), bus.hs_max, tbl[i].hs_max);
         chk($sformatf("v%0d_hs_rise", i), bus.hs_rise, tbl[i].hs_rise);
         chk($sformatf("v%0d_lines", i), bus.lines, tbl[i].lines);
         chk($sformatf("v%0d_scanlines", i), bus.scanlines, 0);
         chk($sformatf("v%0d_mc_count", i), mc_cnt, tbl[i].mc);
      end

      // Scanline requests take effect only at frame boundaries and wrap 3->0.
      htot   = 448;
      rise_p = 401;
      repeat (50) adv();
      repeat (3) pulse_scan();
      repeat (20) adv();
      chk("scan_mid_frame", bus.scanlines, 0);
      run_frame();
      settle();
      chk("scan_commit3", bus.scanlines, 3);
      chk("scan_commit3_mc", mc_cnt, 4);
      chk("scan_commit3_locked", bus.locked, 1);
      repeat (50) adv();
      pulse_scan();
      run_frame();
      settle();
      chk("scan_wrap", bus.scanlines, 0);
      chk("scan_wrap_mc", mc_cnt, 5);

      // force_bypass is held until the next frame start.
      repeat (100) adv();
      bus.force_bypass = 1'b1;
      repeat (100) adv();
      chk("bypass_mid_frame", bus.sd_enable, 1);
      run_frame();
      settle();
      chk("bypass_commit_en", bus.sd_enable, 0);
      chk("bypass_commit_locked", bus.locked, 1);
      chk("bypass_commit_mc", mc_cnt, 6);
      bus.force_bypass = 1'b0;
      run_frame();
      settle();
      chk("bypass_release_en", bus.sd_enable, 1);
      chk("bypass_release_mc", mc_cnt, 7);

      // hsync stops: hcnt saturates on the 1023rd ce cycle after line start.
      repeat (1022) ce_step(1'b0, 1'b0);
      settle();
      chk("pre_timeout_locked", bus.locked, 1);
      ce_step(1'b0, 1'b0);
      settle();
      chk("timeout_locked", bus.locked, 0);
      chk("timeout_sd_enable", bus.sd_enable, 0);
      chk("timeout_mc", mc_cnt, 8);

      // Short lines never qualify as valid video.
      htot   = 200;
      rise_p = 150;
      pos    = 0;
      line   = 0;
      for (int f = 0; f < 10; f++) begin
         run_frame();
         settle();
         chk($sformatf("short%0d_locked", f), bus.locked, 0);
         chk($sformatf("short%0d_sd_enable", f), bus.sd_enable, 0);
      end

      // Asynchronous reset mid-frame, committed timing was non-zero before.
      repeat (300) adv();
      #1;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (2) begin
         @(posedge clk_x2); #1;
      end
      reset_n = 1'b1;
      run_frame();
      settle();
      chk("post_reset_locked", bus.locked, 0);
      chk("post_reset_hs_max", bus.hs_max, 0);
      chk("post_reset_sd_enable", bus.sd_enable, 0);

      chk("mode_change_width", mc_wide, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
